// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: channel state encoding,
// default bus widths and a small index-width helper.
package gpu_mem_pkg;

    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } ch_state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// LSU-side and memory-side bundle of the data-memory arbiter.
// master: arbiter view; slave: LSU threads plus external memory.
interface data_mem_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport master (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address,
        input  consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport slave (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address,
        output consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

endinterface

// File: rtl/data_mem_arbiter_channel.sv
// One memory channel: FSM plus the latched request of its current owner.
// Write states exist only when DATA_MEM_ARB_WRITE_EN is defined.
module mem_arb_channel
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int IDX_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic                 grant_rd,
    input  logic [IDX_BITS-1:0]  grant_idx,
    input  logic [ADDR_BITS-1:0] grant_addr,
    input  logic [DATA_BITS-1:0] grant_wdata,
    input  logic                 owner_rd_valid,
    input  logic                 owner_wr_valid,
    input  logic                 mem_read_ready,
    input  logic                 mem_write_ready,
    output ch_state_t            state,
    output logic [IDX_BITS-1:0]  owner,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    output logic                 rd_load,
    output logic                 done
);

    // rd_load: top captures mem_read_data into the owner's data register
    assign rd_load = (state == READ_WAITING) && mem_read_ready;

`ifdef DATA_MEM_ARB_WRITE_EN
    assign done = ((state == READ_RELAYING) && !owner_rd_valid) ||
                  ((state == WRITE_RELAYING) && !owner_wr_valid);
`else
    assign done = (state == READ_RELAYING) && !owner_rd_valid;
    assign mem_write_valid   = 1'b0;
    assign mem_write_address = '0;
    assign mem_write_data    = '0;

    logic unused_wr;
    assign unused_wr = ^{grant_rd, grant_wdata, owner_wr_valid,
                         mem_write_ready};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
`ifdef DATA_MEM_ARB_WRITE_EN
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner <= grant_idx;
`ifdef DATA_MEM_ARB_WRITE_EN
                        if (!grant_rd) begin
                            state             <= WRITE_WAITING;
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= grant_addr;
                            mem_write_data    <= grant_wdata;
                        end else
`endif
                        begin
                            state            <= READ_WAITING;
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= grant_addr;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        state          <= READ_RELAYING;
                    end
                end
                READ_RELAYING: begin
                    if (!owner_rd_valid) state <= IDLE;
                end
`ifdef DATA_MEM_ARB_WRITE_EN
                WRITE_WAITING: begin
                    if (mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        state           <= WRITE_RELAYING;
                    end
                end
                WRITE_RELAYING: begin
                    if (!owner_wr_valid) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter of NUM_CONSUMERS LSU ports onto NUM_CHANNELS
// memory channels. DATA_MEM_ARB_WRITE_EN enables the write path.
module data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input logic               clk,
    input logic               reset,
    data_mem_arbiter_if.master bus
);
    localparam int IW = idx_bits(NUM_CONSUMERS);

    logic [NUM_CONSUMERS-1:0] claimed, claim_set, claim_clr, want;
    logic [NUM_CONSUMERS-1:0] rd_rdy, wr_rdy;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q;

    logic [NUM_CHANNELS-1:0][IW-1:0] rr_ptr, grant_idx, owner;
    logic [NUM_CHANNELS-1:0] grant, grant_rd, rd_load, done;
    logic [NUM_CHANNELS-1:0] own_rv, own_wv;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_wdata;
    ch_state_t ch_state [NUM_CHANNELS];

`ifdef DATA_MEM_ARB_WRITE_EN
    assign want = bus.consumer_read_valid | bus.consumer_write_valid;
`else
    assign want = bus.consumer_read_valid;

    logic unused_wr;
    assign unused_wr = ^{bus.consumer_write_valid,
                         bus.consumer_write_address,
                         bus.consumer_write_data};
`endif

    // Channels resolve in index order; claim_set doubles as the
    // "taken this cycle" mask so a lower channel's pick is skipped.
    always_comb begin
        int c;
        c           = 0;
        claim_set   = '0;
        grant       = '0;
        grant_rd    = '0;
        grant_idx   = '0;
        grant_addr  = '0;
        grant_wdata = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (ch_state[ch] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    c = int'(rr_ptr[ch]) + k;
                    if (c >= NUM_CONSUMERS) c = c - NUM_CONSUMERS;
                    if (!grant[ch] && want[c] &&
                        !claimed[c] && !claim_set[c]) begin
                        grant[ch]     = 1'b1;
                        grant_idx[ch] = IW'(c);
                        claim_set[c]  = 1'b1;
`ifdef DATA_MEM_ARB_WRITE_EN
                        grant_rd[ch]    = bus.consumer_read_valid[c];
                        grant_wdata[ch] = bus.consumer_write_data[c];
                        grant_addr[ch]  = bus.consumer_read_valid[c] ?
                                          bus.consumer_read_address[c] :
                                          bus.consumer_write_address[c];
`else
                        grant_rd[ch]   = 1'b1;
                        grant_addr[ch] = bus.consumer_read_address[c];
`endif
                    end
                end
            end
        end
    end

    always_comb begin
        claim_clr = '0;
        rd_rdy    = '0;
        wr_rdy    = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (done[ch]) claim_clr[owner[ch]] = 1'b1;
            if (ch_state[ch] == READ_RELAYING) rd_rdy[owner[ch]] = 1'b1;
            if (ch_state[ch] == WRITE_RELAYING) wr_rdy[owner[ch]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            claimed <= '0;
            rr_ptr  <= '0;
            rdata_q <= '0;
        end else begin
            claimed <= (claimed & ~claim_clr) | claim_set;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (grant[ch])
                    rr_ptr[ch] <= (int'(grant_idx[ch]) == NUM_CONSUMERS - 1)
                                  ? '0 : grant_idx[ch] + 1'b1;
                if (rd_load[ch])
                    rdata_q[owner[ch]] <= bus.mem_read_data[ch];
            end
        end
    end

    assign bus.consumer_read_ready = rd_rdy;
    assign bus.consumer_read_data  = rdata_q;
`ifdef DATA_MEM_ARB_WRITE_EN
    assign bus.consumer_write_ready = wr_rdy;
`else
    assign bus.consumer_write_ready = '0;

    logic unused_wrdy;
    assign unused_wrdy = ^wr_rdy;
`endif

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_ch
        assign own_rv[ch] = bus.consumer_read_valid[owner[ch]];
        assign own_wv[ch] = bus.consumer_write_valid[owner[ch]];

        mem_arb_channel #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .IDX_BITS  (IW)
        ) u_ch (
            .clk               (clk),
            .reset             (reset),
            .grant             (grant[ch]),
            .grant_rd          (grant_rd[ch]),
            .grant_idx         (grant_idx[ch]),
            .grant_addr        (grant_addr[ch]),
            .grant_wdata       (grant_wdata[ch]),
            .owner_rd_valid    (own_rv[ch]),
            .owner_wr_valid    (own_wv[ch]),
            .mem_read_ready    (bus.mem_read_ready[ch]),
            .mem_write_ready   (bus.mem_write_ready[ch]),
            .state             (ch_state[ch]),
            .owner             (owner[ch]),
            .mem_read_valid    (bus.mem_read_valid[ch]),
            .mem_read_address  (bus.mem_read_address[ch]),
            .mem_write_valid   (bus.mem_write_valid[ch]),
            .mem_write_address (bus.mem_write_address[ch]),
            .mem_write_data    (bus.mem_write_data[ch]),
            .rd_load           (rd_load[ch]),
            .done              (done[ch])
        );
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: 1-channel and 2-channel
// instances driven by behavioural LSU threads and a fixed-latency memory.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.NUM_CHANNELS(1)) bus ();
    data_mem_arbiter_if #(.NUM_CHANNELS(2)) bus2 ();

    data_mem_arbiter #(.NUM_CHANNELS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    data_mem_arbiter #(.NUM_CHANNELS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [11:0] exp_q [$];
    logic [15:0] wexp_q [$];
    logic mem_hold = 1'b0;
    logic force_rdy = 1'b0;
    int rcnt = 0;
    int wcnt = 0;
    int rcnt2 [2] = '{0, 0};
    logic [3:0] prev_rdy = '0;

    function automatic logic [7:0] mem_f(input logic [7:0] a);
        return a * 8'd7 + 8'h35;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // memory for the 1-channel instance
    always @(negedge clk) begin
        logic [15:0] w;
        if (mem_hold) begin
            bus.mem_read_ready[0] = force_rdy;
            bus.mem_read_data[0]  = 8'hEE;
            rcnt = 0;
        end else if (bus.mem_read_ready[0] === 1'b1) begin
            bus.mem_read_ready[0] = 1'b0;
        end else if (bus.mem_read_valid[0]) begin
            rcnt++;
            if (rcnt == LAT) begin
                rcnt = 0;
                bus.mem_read_ready[0] = 1'b1;
                bus.mem_read_data[0]  = mem_f(bus.mem_read_address[0]);
            end
        end else begin
            bus.mem_read_ready[0] = 1'b0;
            rcnt = 0;
        end
        if (bus.mem_write_ready[0] === 1'b1) begin
            bus.mem_write_ready[0] = 1'b0;
        end else if (bus.mem_write_valid[0]) begin
            wcnt++;
            if (wcnt == LAT) begin
                wcnt = 0;
                bus.mem_write_ready[0] = 1'b1;
                if (wexp_q.size() == 0) begin
                    chk("wr_unexp", 32'(bus.mem_write_valid), 32'd0);
                end else begin
                    w = wexp_q.pop_front();
                    chk("wr_addr", 32'(bus.mem_write_address[0]),
                        32'(w[15:8]));
                    chk("wr_data", 32'(bus.mem_write_data[0]),
                        32'(w[7:0]));
                end
            end
        end else begin
            bus.mem_write_ready[0] = 1'b0;
            wcnt = 0;
        end
    end

    // memory for the 2-channel instance (reads only)
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (bus2.mem_read_ready[ch] === 1'b1) begin
                bus2.mem_read_ready[ch] = 1'b0;
            end else if (bus2.mem_read_valid[ch]) begin
                rcnt2[ch]++;
                if (rcnt2[ch] == LAT) begin
                    rcnt2[ch] = 0;
                    bus2.mem_read_ready[ch] = 1'b1;
                    bus2.mem_read_data[ch] =
                        mem_f(bus2.mem_read_address[ch]);
                end
            end else begin
                bus2.mem_read_ready[ch] = 1'b0;
                rcnt2[ch] = 0;
            end
        end
    end

    // read completions of the 1-channel instance against the scoreboard
    always @(negedge clk) begin
        logic [11:0] e;
        for (int c = 0; c < 4; c++) begin
            if (bus.consumer_read_ready[c] && !prev_rdy[c]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("rd_unexp%0d", c),
                        32'(bus.consumer_read_ready[c]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_who", 32'(c), 32'(e[11:8]));
                    chk("rd_data", 32'(bus.consumer_read_data[c]),
                        32'(e[7:0]));
                end
            end
        end
        prev_rdy = bus.consumer_read_ready;
    end

    task automatic cons_read(input int c, input logic [7:0] a);
        int n;
        @(negedge clk);
        bus.consumer_read_address[c] = a;
        bus.consumer_read_valid[c] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.consumer_read_ready[c] && n < 300);
        chk($sformatf("rd_done%0d", c),
            32'(bus.consumer_read_ready[c]), 32'd1);
        bus.consumer_read_valid[c] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, got timeout expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.consumer_read_valid    = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;
        bus2.consumer_read_valid    = '0;
        bus2.consumer_read_address  = '0;
        bus2.consumer_write_valid   = '0;
        bus2.consumer_write_address = '0;
        bus2.consumer_write_data    = '0;
        bus2.mem_write_ready        = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mrv", 32'(bus.mem_read_valid), 32'd0);
        chk("rst_crr", 32'(bus.consumer_read_ready), 32'd0);
        chk("rst_crd", 32'(bus.consumer_read_data), 32'd0);
        chk("rst_mwv", 32'(bus.mem_write_valid), 32'd0);
        chk("rst_cwr", 32'(bus.consumer_write_ready), 32'd0);
        chk("rst_mrv2", 32'(bus2.mem_read_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // single read, consumer 2
        @(negedge clk);
        exp_q.push_back({4'd2, mem_f(8'h10)});
        bus.consumer_read_address[2] = 8'h10;
        bus.consumer_read_valid[2] = 1'b1;
        chk("sr_pre", 32'(bus.mem_read_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("sr_mrv", 32'(bus.mem_read_valid), 32'd1);
        chk("sr_addr", 32'(bus.mem_read_address[0]), 32'h10);
        n = 1;
        while (!bus.consumer_read_ready[2] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sr_lat", 32'(n), 32'd4);
        chk("sr_mrv_off", 32'(bus.mem_read_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("sr_hold", 32'(bus.consumer_read_ready[2]), 32'd1);
        @(negedge clk);
        bus.consumer_read_valid[2] = 1'b0;
        @(posedge clk);
        #1;
        chk("sr_drop", 32'(bus.consumer_read_ready[2]), 32'd0);
        chk("sr_keep", 32'(bus.consumer_read_data[2]), 32'hA5);

`ifdef DATA_MEM_ARB_WRITE_EN
        @(negedge clk);
        wexp_q.push_back({8'h20, 8'h7E});
        bus.consumer_write_address[1] = 8'h20;
        bus.consumer_write_data[1] = 8'h7E;
        bus.consumer_write_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_mwv", 32'(bus.mem_write_valid), 32'd1);
        chk("wr_ma", 32'(bus.mem_write_address[0]), 32'h20);
        chk("wr_md", 32'(bus.mem_write_data[0]), 32'h7E);
        n = 0;
        while (!bus.consumer_write_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_rdy", 32'(bus.consumer_write_ready[1]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("wr_held", 32'(bus.consumer_write_ready[1]), 32'd1);
        end
        bus.consumer_write_valid[1] = 1'b0;
        @(negedge clk);
        chk("wr_drop", 32'(bus.consumer_write_ready[1]), 32'd0);
`endif

        // reset while a read waits on memory
        mem_hold = 1'b1;
        @(negedge clk);
        bus.consumer_read_address[0] = 8'h33;
        bus.consumer_read_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("mr_wait", 32'(bus.mem_read_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_mrv", 32'(bus.mem_read_valid), 32'd0);
        chk("mr_mra", 32'(bus.mem_read_address), 32'd0);
        chk("mr_crr", 32'(bus.consumer_read_ready), 32'd0);
        chk("mr_crd", 32'(bus.consumer_read_data), 32'd0);
        force_rdy = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.consumer_read_valid[0] = 1'b0;
        @(posedge clk);
        #1;
        force_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_ign", 32'(bus.consumer_read_ready), 32'd0);
        chk("mr_idle", 32'(bus.mem_read_valid), 32'd0);
        mem_hold = 1'b0;

        // contention on one channel, two rounds each
        for (int c = 0; c < 4; c++)
            exp_q.push_back({4'(c), mem_f(8'(8'h40 + c))});
        for (int c = 0; c < 4; c++)
            exp_q.push_back({4'(c), mem_f(8'(8'h50 + c))});
        fork
            begin cons_read(0, 8'h40); cons_read(0, 8'h50); end
            begin cons_read(1, 8'h41); cons_read(1, 8'h51); end
            begin cons_read(2, 8'h42); cons_read(2, 8'h52); end
            begin cons_read(3, 8'h43); cons_read(3, 8'h53); end
        join

        // fresh read after all that
        exp_q.push_back({4'd3, mem_f(8'h77)});
        cons_read(3, 8'h77);

        // two channels, consumers 0 and 3 together
        @(negedge clk);
        bus2.consumer_read_address[0] = 8'h61;
        bus2.consumer_read_address[3] = 8'h63;
        bus2.consumer_read_valid[0] = 1'b1;
        bus2.consumer_read_valid[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("c2_mrv", 32'(bus2.mem_read_valid), 32'd3);
        chk("c2_a0", 32'(bus2.mem_read_address[0]), 32'h61);
        chk("c2_a1", 32'(bus2.mem_read_address[1]), 32'h63);
        n = 0;
        while (!(bus2.consumer_read_ready[0] && bus2.consumer_read_ready[3])
               && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("c2_rdy", 32'({bus2.consumer_read_ready[3],
                           bus2.consumer_read_ready[0]}), 32'd3);
        chk("c2_d0", 32'(bus2.consumer_read_data[0]), 32'(mem_f(8'h61)));
        chk("c2_d3", 32'(bus2.consumer_read_data[3]), 32'(mem_f(8'h63)));
        bus2.consumer_read_valid[0] = 1'b0;
        bus2.consumer_read_valid[3] = 1'b0;
        @(negedge clk);
        bus2.consumer_read_address[1] = 8'h62;
        bus2.consumer_read_valid[1] = 1'b1;
        repeat (LAT) begin
            @(posedge clk);
            #1;
            chk("c2_single", 32'(bus2.mem_read_valid), 32'd1);
        end
        n = 0;
        while (!bus2.consumer_read_ready[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("c2_d1", 32'(bus2.consumer_read_data[1]), 32'(mem_f(8'h62)));
        bus2.consumer_read_valid[1] = 1'b0;

`ifndef DATA_MEM_ARB_WRITE_EN
        // write-only request is never served; reads still go through
        @(negedge clk);
        bus.consumer_write_address[0] = 8'h22;
        bus.consumer_write_data[0] = 8'h99;
        bus.consumer_write_valid[0] = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("nw_out", 32'({bus.mem_write_valid, bus.mem_read_valid,
                               bus.consumer_write_ready[0]}), 32'd0);
        end
        exp_q.push_back({4'd0, mem_f(8'h44)});
        cons_read(0, 8'h44);
        chk("nw_cwr", 32'(bus.consumer_write_ready), 32'd0);
        bus.consumer_write_valid[0] = 1'b0;
`endif

        repeat (4) @(negedge clk);
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        chk("wsb_left", 32'(wexp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Sits directly downstream of the compute cores' per-thread LSU data-memory ports and upstream of external data memory.
- Arbitrates NUM_CONSUMERS independent LSU request ports onto NUM_CHANNELS memory channels.
- Relays read data and write acknowledgements back to the requesting thread.
- Uses round-robin consumer selection per channel, so no thread starves under contention.

Parameters:
- ADDR_BITS, 8, data memory address width
- DATA_BITS, 8, data word width
- NUM_CONSUMERS, 4, LSU ports served (cores x THREADS_PER_BLOCK)
- NUM_CHANNELS, 1, concurrent memory channels; must satisfy 1 <= NUM_CHANNELS <= NUM_CONSUMERS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  [NUM_CONSUMERS]  per-thread read request
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid, held until request drops
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned read data
- consumer_write_valid  in  [NUM_CONSUMERS]  per-thread write request
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write done, held until request drops
- mem_read_valid  out  [NUM_CHANNELS]  memory read request
- mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]  memory read address
- mem_read_ready  in  [NUM_CHANNELS]  memory read complete
- mem_read_data  in  [NUM_CHANNELS][DATA_BITS]  memory read data
- mem_write_valid  out  [NUM_CHANNELS]  memory write request
- mem_write_address  out  [NUM_CHANNELS][ADDR_BITS]  memory write address
- mem_write_data  out  [NUM_CHANNELS][DATA_BITS]  memory write data
- mem_write_ready  in  [NUM_CHANNELS]  memory write complete

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high.
- On reset:
  - All outputs are 0.
  - Every channel returns to IDLE.
  - The claim mask clears and round-robin pointers go to 0.
  - An in-flight memory transaction is abandoned; no consumer ready is issued for it.
- Per-channel FSM states: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE:
  - Scan consumers from rr_ptr[ch] upward, wrapping modulo NUM_CONSUMERS.
  - Grant the first consumer that is unclaimed and has read_valid or write_valid asserted.
  - Read wins if a consumer asserts both.
  - On a read grant: latch the address, drive mem_read_valid next cycle, go to READ_WAITING. Writes are the analogue (address and data latched, WRITE_WAITING).
  - On any grant: set claimed[c] and set rr_ptr[ch] = (c+1) mod NUM_CONSUMERS.
- Same-cycle multi-channel grants: channels resolve in ascending index order. A consumer granted by a lower channel is ineligible for higher channels in that cycle. No consumer is ever held by two channels.
- READ_WAITING / WRITE_WAITING: hold mem_*_valid and address/data stable until mem_*_ready is sampled high. Then:
  - Drop mem_*_valid.
  - Assert consumer_*_ready[c]; for reads, register mem_read_data into consumer_read_data[c].
  - Go to *_RELAYING.
- *_RELAYING:
  - Hold consumer_*_ready[c] high until the consumer's valid is sampled low.
  - Then drop ready, clear claimed[c], return to IDLE.
  - That consumer is eligible again the following cycle.
- Latency, request sampled at cycle t in IDLE:
  - mem valid high at t+1.
  - mem ready sampled at t+k gives consumer ready and data at t+k+1.
  - Minimum round trip for a consumer that drops valid immediately is 4 cycles.
- Boundaries:
  - Consumer drops valid before completion: the transaction still completes to memory; ready pulses for one cycle, then the channel returns to IDLE.
  - No requests: channels stay in IDLE and pointers do not move.
  - More requesters than channels: the rest wait, with no lost requests.
- consumer_read_data[c] retains its last value when not ready.

Optional Feature:
- Macro: DATA_MEM_ARB_WRITE_EN.
- Defined: full read/write arbitration as above.
- Undefined: read-only arbiter, suitable for program memory.
  - Write ports remain present; write inputs are ignored.
  - mem_write_valid, mem_write_address, mem_write_data and consumer_write_ready are constant 0.
  - WRITE_* states are not generated.
  - A consumer asserting only write_valid is never granted.

Decomposition:
- Shared package gpu_mem_pkg holds:
  - the channel state enum (3-bit encoding IDLE=0, READ_WAITING=1, WRITE_WAITING=2, READ_RELAYING=3, WRITE_RELAYING=4)
  - the default ADDR_BITS/DATA_BITS constants
- Natural sub-module: mem_arb_channel, one FSM plus latched request.
  - Instantiated NUM_CHANNELS times.
  - Fed by a top-level claim/round-robin grant block.

Test Plan:
- Single read: consumer 2 reads 0x10, memory returns 0xA5 with ready 3 cycles after valid -> consumer_read_ready[2] high with data 0xA5; mem_read_valid asserted exactly 1 cycle after request.
- Write (macro defined): consumer 1 writes 0x7E to 0x20 -> mem_write_address=0x20, data=0x7E; consumer_write_ready[1] held until valid drops.
- Contention, 1 channel: all 4 consumers read simultaneously and re-request immediately -> service order 0,1,2,3,0; no consumer served twice before others.
- 2 channels: consumers 0 and 3 request in the same cycle -> channel 0 takes consumer 0, channel 1 takes consumer 3, both mem valids high the same cycle; a single request is never granted twice.
- Reset mid-READ_WAITING: reset asserted -> next cycle all outputs 0; a later memory ready is ignored; a fresh request is serviced normally.
- Macro undefined: consumer 0 asserts only write_valid for 20 cycles -> mem_write_valid stays 0 and consumer_write_ready[0] stays 0; reads still work.
